// File: rtl/mips_ifetch_queue_if.sv
// mips_ifetch_queue_if
//   Bundles the instruction-fetch queue's memory request/response channel,
//   its decode-side valid/ready channel and the redirect/halt controls.
//   Port summary:
//     mem_req/mem_addr      : fetch request driven by the queue
//     mem_gnt               : request accepted by instruction memory
//     mem_rvalid/mem_rdata  : in-order response from instruction memory
//     id_valid/id_ir/id_npc : queue head presented to decode
//     id_ready              : decode accepts the head
//     redirect_valid/_pc    : taken-branch flush and restart address
//     halt                  : level, stops new requests
//   Modports: master = fetch queue, slave = memory/decode/branch side.
interface mips_ifetch_queue_if #(
  parameter int ADDR_W = 10
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_ir;
  logic [31:0]       id_npc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  modport master (
    output mem_req, mem_addr, id_valid, id_ir, id_npc,
    input  mem_gnt, mem_rvalid, mem_rdata, id_ready,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  mem_req, mem_addr, id_valid, id_ir, id_npc,
    output mem_gnt, mem_rvalid, mem_rdata, id_ready,
           redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/mips_ifetch_queue.sv
// mips_ifetch_queue
//   Instruction prefetch queue in front of the MIPS32 decode stage. Issues
//   in-order word fetches over req/gnt, collects in-order rvalid responses
//   into a DEPTH-entry FIFO of {instruction, next PC} and presents the head
//   to decode over valid/ready. A taken-branch redirect flushes the FIFO,
//   reloads the fetch/response PCs and marks every outstanding response
//   for discard.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : mips_ifetch_queue_if.master (memory, decode, redirect, halt)
//   Parameters: DEPTH (power of 2, 2..16), ADDR_W (word-address width),
//     RESET_PC (first fetch word address).
//   Optional feature: define MIPS_IFQ_HLT_STOP_EN to predecode pushed words
//     and stop requesting after an HLT opcode (6'b111111) until redirect.
module mips_ifetch_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input logic                 clk,
  input logic                 rst,
  mips_ifetch_queue_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       ir_mem_q  [DEPTH];
  logic [31:0]       ir_mem_d  [DEPTH];
  logic [ADDR_W-1:0] npc_mem_q [DEPTH];
  logic [ADDR_W-1:0] npc_mem_d [DEPTH];

  logic credit_ok_s;
  logic req_s;
  logic grant_s;
  logic discard_s;
  logic push_s;
  logic pop_s;
  logic full_s;
  logic hlt_stop_s;

  // Credit check: buffered plus outstanding words never exceed the FIFO,
  // so every response always has a slot waiting for it.
  assign credit_ok_s = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(DEPTH);
  assign req_s       = !rst && !bus.halt && !bus.redirect_valid && credit_ok_s && !hlt_stop_s;
  assign grant_s     = req_s && bus.mem_gnt;
  assign discard_s   = bus.mem_rvalid && (drop_q != {CNT_W{1'b0}});
  assign push_s      = bus.mem_rvalid && !discard_s && !bus.redirect_valid;
  assign pop_s       = (count_q != {CNT_W{1'b0}}) && bus.id_ready && !bus.redirect_valid;
  assign full_s      = (count_q == CNT_W'(DEPTH));

  assign bus.mem_req  = req_s;
  assign bus.mem_addr = fetch_pc_q;
  assign bus.id_valid = (count_q != {CNT_W{1'b0}});
  assign bus.id_ir    = ir_mem_q[rd_ptr_q];
  assign bus.id_npc   = 32'(npc_mem_q[rd_ptr_q]);

  // Next-state for PCs, occupancy counters, pointers and FIFO storage.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ir_mem_d   = ir_mem_q;
    npc_mem_d  = npc_mem_q;
    if (bus.redirect_valid) begin
      // Every response still outstanding belongs to the old path, including
      // ones already marked for discard; a response this cycle retires one.
      fetch_pc_d = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      count_d    = {CNT_W{1'b0}};
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      inflight_d = inflight_q - CNT_W'(bus.mem_rvalid);
      drop_d     = inflight_q - CNT_W'(bus.mem_rvalid);
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      inflight_d = inflight_q + CNT_W'(grant_s) - CNT_W'(bus.mem_rvalid);
      if (discard_s) begin
        drop_d = drop_q - CNT_W'(1);
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        ir_mem_d[wr_ptr_q]  = bus.mem_rdata;
        npc_mem_d[wr_ptr_q] = resp_pc_q + ADDR_W'(1);
        resp_pc_d           = resp_pc_q + ADDR_W'(1);
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end else begin
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC_W;
      resp_pc_q  <= RESET_PC_W;
      count_q    <= {CNT_W{1'b0}};
      inflight_q <= {CNT_W{1'b0}};
      drop_q     <= {CNT_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_q[i]  <= 32'h0000_0000;
        npc_mem_q[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ir_mem_q   <= ir_mem_d;
      npc_mem_q  <= npc_mem_d;
    end
  end

`ifdef MIPS_IFQ_HLT_STOP_EN
  logic hlt_seen_q, hlt_seen_d;

  function automatic logic is_hlt(input logic [31:0] word);
    return (word[31:26] == 6'b111111);
  endfunction

  // HLT latch: set when an HLT word is stored, cleared only by redirect.
  always_comb begin
    if (bus.redirect_valid) begin
      hlt_seen_d = 1'b0;
    end else if (push_s && is_hlt(bus.mem_rdata)) begin
      hlt_seen_d = 1'b1;
    end else begin
      hlt_seen_d = hlt_seen_q;
    end
  end

  // HLT latch register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hlt_seen_q <= 1'b0;
    end else begin
      hlt_seen_q <= hlt_seen_d;
    end
  end

  assign hlt_stop_s = hlt_seen_q;
`else
  assign hlt_stop_s = 1'b0;
`endif

`ifndef SYNTHESIS
  mips_ifetch_queue_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .full (full_s)
  );
`endif

endmodule

// mips_ifetch_queue_chk
//   Simulation-only protocol checker: a push into a full FIFO means the
//   credit accounting has been broken.
//   Ports: clk, rst, push (word stored this cycle), full (FIFO full).
module mips_ifetch_queue_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  // Overflow check on every clock outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full))
        else $error("mips_ifetch_queue: push into full queue");
    end
  end
endmodule

// File: tb/tb_mips_ifetch_queue.sv
// tb_mips_ifetch_queue
//   Directed bench for mips_ifetch_queue: a fixed-latency in-order memory
//   model, a decode-side pop recorder and hand-computed expectations.
module tb_mips_ifetch_queue;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;

  mips_ifetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  mips_ifetch_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:1023];
  int          lat;
  logic        gnt_en;
  int          cyc = 0;
  int          pend_addr[$];
  int          pend_due[$];
  logic [31:0] pop_ir[$];
  logic [31:0] pop_npc[$];
  int          gnt_log[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pir(input int i);
    if (i < pop_ir.size()) return pop_ir[i];
    return 32'hdead_beef;
  endfunction

  function automatic logic [31:0] pnpc(input int i);
    if (i < pop_npc.size()) return pop_npc[i];
    return 32'hdead_beef;
  endfunction

  function automatic int glog(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return -1;
  endfunction

  // Memory model and pop recorder; evaluated mid-cycle for the next edge.
  initial begin
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        pop_ir.delete();
        pop_npc.delete();
        gnt_log.delete();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
      end else begin
        if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
          pop_ir.push_back(bus.id_ir);
          pop_npc.push_back(bus.id_npc);
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = imem[pend_addr[0]];
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = 32'h0;
        end
        if (bus.mem_req && gnt_en) begin
          bus.mem_gnt = 1'b1;
          pend_addr.push_back(int'(bus.mem_addr));
          pend_due.push_back(cyc + lat);
          gnt_log.push_back(int'(bus.mem_addr));
        end else begin
          bus.mem_gnt = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    lat                = l;
    gnt_en             = 1'b1;
    rst                = 1'b1;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (pop_ir.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(pop_ir.size() >= n), 32'd1);
  endtask

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "tb_mips_ifetch_queue watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 | 32'(i);
    imem[0] = 32'h2801_000a;
    imem[1] = 32'h2802_0014;
    imem[2] = 32'h2803_0019;
    imem[8] = 32'hfc00_0000;

    // Reset state
    rst = 1'b1; bus.id_ready = 1'b0; bus.halt = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; lat = 2; gnt_en = 1'b1;
    #2;
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check_eq("rst_id_ir", bus.id_ir, 32'h0);
    check_eq("rst_id_npc", bus.id_npc, 32'h0);

    // Basic streaming, 2-cycle latency
    bus.id_ready = 1'b1;
    do_reset(2);
    wait_pops("t1_pops", 3, 40);
    check_eq("t1_ir0", pir(0), 32'h2801_000a);
    check_eq("t1_npc0", pnpc(0), 32'd1);
    check_eq("t1_ir1", pir(1), 32'h2802_0014);
    check_eq("t1_npc1", pnpc(1), 32'd2);
    check_eq("t1_ir2", pir(2), 32'h2803_0019);
    check_eq("t1_npc2", pnpc(2), 32'd3);
    for (int i = 0; i < 4; i++) check_eq("t1_addr", 32'(glog(i)), 32'(i));

    // Back-pressure: credit limit of 4
    bus.id_ready = 1'b0;
    do_reset(2);
    tick(12);
    check_eq("t2_grants", 32'(gnt_log.size()), 32'd4);
    check_eq("t2_req_low", 32'(bus.mem_req), 32'd0);
    check_eq("t2_valid", 32'(bus.id_valid), 32'd1);
    check_eq("t2_head_ir", bus.id_ir, 32'h2801_000a);
    check_eq("t2_head_npc", bus.id_npc, 32'd1);
    bus.id_ready = 1'b1;
    wait_pops("t2_pops", 6, 40);
    for (int i = 0; i < 6; i++) begin
      check_eq("t2_ir", pir(i), imem[i]);
      check_eq("t2_npc", pnpc(i), 32'(i + 1));
    end
    check_eq("t2_resumed", 32'(gnt_log.size() > 4), 32'd1);

    // Redirect with 3 in flight and a response in the same cycle
    bus.id_ready = 1'b1;
    do_reset(3);
    tick(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h020;
    #1;
    check_eq("t3_req_low", 32'(bus.mem_req), 32'd0);
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    check_eq("t3_addr", 32'(bus.mem_addr), 32'h20);
    check_eq("t3_req", 32'(bus.mem_req), 32'd1);
    wait_pops("t3_pops", 2, 30);
    check_eq("t3_ir0", pir(0), imem[32'h20]);
    check_eq("t3_npc0", pnpc(0), 32'h21);
    check_eq("t3_npc1", pnpc(1), 32'h22);
    check_eq("t3_gnt3", 32'(glog(3)), 32'h20);

    // Redirect with a pop on a full queue
    bus.id_ready = 1'b0;
    do_reset(2);
    tick(10);
    check_eq("t4_full_valid", 32'(bus.id_valid), 32'd1);
    pop_ir.delete();
    pop_npc.delete();
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h040;
    tick(1);
    bus.redirect_valid = 1'b0;
    check_eq("t4_valid_low", 32'(bus.id_valid), 32'd0);
    check_eq("t4_no_pop", 32'(pop_ir.size()), 32'd0);
    wait_pops("t4_pops", 1, 30);
    check_eq("t4_ir0", pir(0), imem[32'h40]);
    check_eq("t4_npc0", pnpc(0), 32'h41);

    // Halt with 2 in flight
    bus.id_ready = 1'b1;
    do_reset(3);
    tick(2);
    bus.halt = 1'b1;
    #1;
    check_eq("t5_req_low", 32'(bus.mem_req), 32'd0);
    tick(8);
    check_eq("t5_grants", 32'(gnt_log.size()), 32'd2);
    check_eq("t5_npops", 32'(pop_ir.size()), 32'd2);
    check_eq("t5_ir0", pir(0), imem[0]);
    check_eq("t5_npc1", pnpc(1), 32'd2);
    check_eq("t5_drained", 32'(bus.id_valid), 32'd0);
    bus.halt = 1'b0;
    #1;
    check_eq("t5_resume_addr", 32'(bus.mem_addr), 32'd2);
    check_eq("t5_resume_req", 32'(bus.mem_req), 32'd1);
    tick(1);
    check_eq("t5_gnt2", 32'(glog(2)), 32'd2);

    // HLT opcode at word 8
    bus.id_ready = 1'b1;
    do_reset(2);
    tick(30);
`ifdef MIPS_IFQ_HLT_STOP_EN
    check_eq("t6_grants", 32'(gnt_log.size()), 32'd11);
    check_eq("t6_req_low", 32'(bus.mem_req), 32'd0);
    check_eq("t6_npops", 32'(pop_ir.size()), 32'd11);
    check_eq("t6_hlt_ir", pir(8), 32'hfc00_0000);
    check_eq("t6_last_npc", pnpc(10), 32'd11);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h000;
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    check_eq("t6_restart_req", 32'(bus.mem_req), 32'd1);
    check_eq("t6_restart_addr", 32'(bus.mem_addr), 32'd0);
    tick(1);
    check_eq("t6_restart_gnt", 32'(glog(11)), 32'd0);
`else
    check_eq("t6_gnt9", 32'(glog(9)), 32'd9);
    check_eq("t6_past_hlt", 32'(gnt_log.size() > 11), 32'd1);
    check_eq("t6_hlt_ir", pir(8), 32'hfc00_0000);
    check_eq("t6_npc9", pnpc(9), 32'd10);
`endif

    // Back-to-back redirects
    bus.id_ready = 1'b1;
    do_reset(3);
    tick(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'h030;
    tick(1);
    bus.redirect_pc    = 10'h050;
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    check_eq("t7_addr", 32'(bus.mem_addr), 32'h50);
    wait_pops("t7_pops", 1, 30);
    check_eq("t7_ir0", pir(0), imem[32'h50]);
    check_eq("t7_npc0", pnpc(0), 32'h51);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
